// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per clock, trial subtraction
// through a ripple-carry adder. Results and the divide-by-zero flag hold until the next operation completes.

module RCA #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s
);
    logic [W-1:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s[i] = a[i] ^ b[i] ^ c[i];
        if (i < W - 1) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end
endmodule

module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N:0]     a_q, a_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   m_q, m_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;

    logic [N:0]     a_sh;
    logic [N-1:0]   q_sh;
    logic [N:0]     diff;
    logic           fits;

    // {A,Q} shifted left as one register; A is wide enough that this never overflows.
    assign a_sh = (a_q << 1) | {{N{1'b0}}, q_q[N-1]};
    assign q_sh = q_q << 1;

    RCA #(.W(N + 1)) u_sub (
        .a   (a_sh),
        .b   (~{1'b0, m_q}),
        .cin (1'b1),
        .s   (diff)
    );

    assign fits = ~diff[N];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            CALC: begin
                a_d   = fits ? diff : a_sh;
                q_d   = {q_sh[N-1:1], fits};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    quot_d  = q_d;
                    rem_d   = a_d[N-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            default: begin
                // IDLE and DONE accept a new request identically, giving back-to-back issue.
                state_d = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        a_d     = '0;
                        q_d     = dividend;
                        m_d     = divisor;
                        cnt_d   = CW'(N);
                        state_d = CALC;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, multi-cycle corner
// sequences, and a randomized sweep scored against an arithmetic reference model.

module tb_seq_divider;
    localparam int N = 8;
    localparam int W = 2 * N + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [N-1:0] dvd;
        logic [N-1:0] dvs;
        logic [N-1:0] quot;
        logic [N-1:0] rem;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference: plain integer division; divide-by-zero returns all ones and the dividend.
    function automatic logic [W-1:0] model(input logic [N-1:0] dvd, input logic [N-1:0] dvs);
        logic [N-1:0] qq;
        logic [N-1:0] rr;
        if (dvs == 0) begin
            qq = {N{1'b1}};
            rr = dvd;
            return {1'b1, rr, qq};
        end
        qq = N'(int'(dvd) / int'(dvs));
        rr = N'(int'(dvd) % int'(dvs));
        return {1'b0, rr, qq};
    endfunction

    // driver: one accepted request, then wait (bounded) for done; lat counts edges incl. the start edge
    task automatic run_op(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        lat      = 1;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            busy_cyc += int'(busy);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busy_cyc;
        logic [W-1:0] exp_v;
        logic [N-1:0] r_dvd;
        logic [N-1:0] r_dvs;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
        vecs[2] = '{8'd5,   8'd10,  8'd0,   8'd5,   1'b0, 9};
        vecs[3] = '{8'd77,  8'd0,   8'd255, 8'd77,  1'b1, 1};
        vecs[4] = '{8'd20,  8'd3,   8'd6,   8'd2,   1'b0, 9};
        vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9};
        vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
        vecs[7] = '{8'd200, 8'd9,   8'd22,  8'd2,   1'b0, 9};
        vecs[8] = '{8'd254, 8'd16,  8'd15,  8'd14,  1'b0, 9};
        vecs[9] = '{8'd128, 8'd255, 8'd0,   8'd128, 1'b0, 9};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_quot", int'(quotient), 0);
        check("reset_rem", int'(remainder), 0);
        check("reset_dbz", int'(div_by_zero), 0);

        // directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].dvd, vecs[i].dvs, lat, busy_cyc);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy", i), busy_cyc, vecs[i].lat - 1);
            check($sformatf("vec%0d_quot", i), int'(quotient), int'(vecs[i].quot));
            check($sformatf("vec%0d_rem", i), int'(remainder), int'(vecs[i].rem));
            check($sformatf("vec%0d_dbz", i), int'(div_by_zero), int'(vecs[i].dbz));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), int'(done), 0);
            check($sformatf("vec%0d_hold_quot", i), int'(quotient), int'(vecs[i].quot));
            check($sformatf("vec%0d_hold_dbz", i), int'(div_by_zero), int'(vecs[i].dbz));
        end

        // start pulses during CALC cycles 3 and 5 must be ignored
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            start    = (lat == 3 || lat == 5);
            dividend = 8'd50;
            divisor  = (lat == 5) ? 8'd0 : 8'd3;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("ignore_lat", lat, 9);
        check("ignore_quot", int'(quotient), 22);
        check("ignore_rem", int'(remainder), 2);
        check("ignore_dbz", int'(div_by_zero), 0);

        // start held high across done: second op issues back-to-back
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk);
        @(negedge clk);
        dividend = 8'd13; divisor = 8'd13;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("b2b_first_lat", lat, 9);
        check("b2b_first_quot", int'(quotient), 14);
        check("b2b_first_rem", int'(remainder), 2);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", int'(busy), 1);
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("b2b_second_lat", lat, 9);
        check("b2b_second_quot", int'(quotient), 1);
        check("b2b_second_rem", int'(remainder), 0);

        // asynchronous reset in CALC cycle 4
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_quot", int'(quotient), 0);
        check("abort_rem", int'(remainder), 0);
        check("abort_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", int'(busy), 0);
        run_op(8'd50, 8'd6, lat, busy_cyc);
        check("post_abort_lat", lat, 9);
        check("post_abort_quot", int'(quotient), 8);
        check("post_abort_rem", int'(remainder), 2);

        // randomized sweep with scoreboard
        for (int k = 0; k < 1000; k++) begin
            r_dvd = N'($urandom_range(0, 255));
            r_dvs = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 255));
            exp_q.push_back(model(r_dvd, r_dvs));
            run_op(r_dvd, r_dvs, lat, busy_cyc);
            exp_v = exp_q.pop_front();
            check("rand_lat", lat, (r_dvs == 0) ? 1 : 9);
            check("rand_quot", int'(quotient), int'(exp_v[N-1:0]));
            check("rand_rem", int'(remainder), int'(exp_v[2*N-1:N]));
            check("rand_dbz", int'(div_by_zero), int'(exp_v[2*N]));
        end

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned radix-2 restoring divider; the inverse operation to the team's Booth multiplier. Shares operand width conventions with it.
- One quotient bit per clock. The trial subtraction uses the team's ripple-carry adder module RCA, instantiated at width N+1 with B = ~divisor and Cin = 1.
- Sits beside the multiplier in the arithmetic datapath, driven by the same start/done style controller.

Parameters:
- N, 8, operand width in bits for the dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only when busy=0.
- dividend  input  N  unsigned dividend; captured on the accepting edge.
- divisor  input  N  unsigned divisor; captured on the accepting edge.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  output  N  unsigned quotient, held until the next accepted start.
- remainder  output  N  unsigned remainder, held until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor was 0; held with the results.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. busy, done, quotient, remainder and div_by_zero all 0. Internal A, Q, M and the counter all 0.
- States: IDLE, CALC, DONE.
- IDLE with start=1, divisor!=0:
  - Load A=0 (N+1 bits), Q=dividend, M=divisor, cnt=N.
  - Go to CALC; busy=1 from the next cycle.
- IDLE with start=1, divisor=0:
  - Go straight to DONE.
  - Load quotient = all ones, remainder = dividend, div_by_zero=1.
  - done is high in the cycle after the accepting edge.
- CALC, once per edge:
  - Shift {A,Q} left by 1.
  - D = A_shifted - M, computed N+1 bits wide through RCA.
  - If D[N]=0: A=D and Q[0]=1. Otherwise A keeps its shifted value and Q[0]=0.
  - cnt decrements.
  - On the edge where cnt goes 1->0: quotient=Q_new, remainder=A_new[N-1:0], div_by_zero=0. Go to DONE.
- DONE lasts exactly 1 cycle: done=1, busy=0.
  - Next state is IDLE. If start=1 in this cycle, the new operation is accepted exactly as from IDLE (back-to-back operation).
- Latency: done is high in the cycle following the Nth edge after the accepting edge, i.e. N+1 edges from the start edge to the done cycle (9 for N=8). Divide-by-zero latency is 1.
- start while busy=1 is ignored: no effect on state, operands or outputs.
- Operand inputs are don't-care except on the accepting edge.
- Outputs hold their last values through IDLE. They are overwritten only on the completing edge of the next operation.
- Arithmetic is unsigned throughout. Invariant: dividend = quotient*divisor + remainder, with remainder < divisor.
- The A register is N+1 bits so the shifted partial remainder cannot overflow.
- rst asserted mid-CALC: immediate abort to IDLE with every output at 0. The first start after rst deasserts is accepted normally.

Test Plan:
- N=8, start with dividend=100, divisor=7 -> busy high for 8 cycles; done pulses 9 edges after the start edge; quotient=14, remainder=2, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=5, divisor=10 -> quotient=0, remainder=5.
- dividend=77, divisor=0 -> done on the cycle after the start edge; quotient=255, remainder=77, div_by_zero=1. The next valid division clears div_by_zero.
- start pulsed again at cycles 3 and 5 of CALC with different operands -> ignored; the original result (e.g. 200/9 -> quotient=22, remainder=2) is unchanged.
- start held high across done -> the second operation (e.g. 13/13) begins back-to-back and gives quotient=1, remainder=0 exactly 9 edges later.
- rst pulsed during CALC cycle 4 -> all outputs 0 immediately, state IDLE. A subsequent 50/6 returns quotient=8, remainder=2. Finish with a random sweep of 1000 operand pairs, including divisor=0, checked against the reference model.
